// File: rtl/vtc_tpg_param.sv
// Parameterised video timing generator with built-in test patterns.
// Bars, checker, ramp or solid fill, switched only at frame start.
module vtc_tpg_param #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int DATA_W    = 8,
  parameter int CH        = 3,
  parameter int CELL_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [CH*DATA_W-1:0] solid_color,
  output logic                 vs,
  output logic                 hs,
  output logic                 de,
  output logic [CH*DATA_W-1:0] data,
  output logic                 sof,
  output logic [15:0]          frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BW      = H_ACTIVE / 8;
  localparam int BXW     = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [BXW-1:0] BX_LAST = BXW'(BW - 1);

  logic [HW-1:0]          h_cnt;
  logic [VW-1:0]          v_cnt;
  logic [2:0]             bar_q;
  logic [BXW-1:0]         bx_q;
  logic [1:0]             mode_q;
  logic [CH*DATA_W-1:0]   solid_q;

  logic                   h_wrap;
  logic                   v_wrap;
  logic                   at_org;
  logic                   active;
  logic                   hs_on;
  logic                   vs_on;
  logic                   chk;
  logic [1:0]             mode_e;
  logic [CH*DATA_W-1:0]   solid_e;
  logic [2:0]             code;
  logic [DATA_W-1:0]      ramp;
  logic [CH*DATA_W-1:0]   pix;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign at_org = (h_cnt == '0) && (v_cnt == '0);
  assign active = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
  assign hs_on  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_on  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign chk    = h_cnt[CELL_LOG2] ^ v_cnt[CELL_LOG2];
  assign ramp   = DATA_W'(h_cnt);

  // The origin pixel already uses the newly sampled pattern.
  assign mode_e  = at_org ? mode : mode_q;
  assign solid_e = at_org ? solid_color : solid_q;

  always_comb begin
    code = 3'b000;
    unique case (bar_q)
      3'd0: code = 3'b111;
      3'd1: code = 3'b110;
      3'd2: code = 3'b011;
      3'd3: code = 3'b010;
      3'd4: code = 3'b101;
      3'd5: code = 3'b100;
      3'd6: code = 3'b001;
      3'd7: code = 3'b000;
    endcase
  end

  always_comb begin
    pix = '0;
    for (int k = 0; k < CH; k++) begin
      unique case (mode_e)
        2'd0: pix[(CH-1-k)*DATA_W +: DATA_W] =
                {DATA_W{code[2 - (k % 3)]}};
        2'd1: pix[(CH-1-k)*DATA_W +: DATA_W] =
                {DATA_W{chk}};
        2'd2: pix[(CH-1-k)*DATA_W +: DATA_W] = ramp;
        2'd3: pix[(CH-1-k)*DATA_W +: DATA_W] =
                solid_e[(CH-1-k)*DATA_W +: DATA_W];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap)
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end
  end

  // Bar index tracked alongside h_cnt; sticks at the last bar.
  always_ff @(posedge clk) begin
    if (rst || !en || h_wrap) begin
      bar_q <= '0;
      bx_q  <= '0;
    end else if (bar_q != 3'd7) begin
      if (bx_q == BX_LAST) begin
        bx_q  <= '0;
        bar_q <= bar_q + 3'd1;
      end else begin
        bx_q <= bx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      solid_q <= '0;
    end else if (en && at_org) begin
      mode_q  <= mode;
      solid_q <= solid_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt <= '0;
    else if (en && h_wrap && v_wrap)
      frame_cnt <= frame_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      de   <= 1'b0;
      sof  <= 1'b0;
      data <= '0;
      hs   <= ~HS_POL;
      vs   <= ~VS_POL;
    end else begin
      de   <= active;
      sof  <= at_org && active;
      data <= active ? pix : '0;
      hs   <= hs_on ? HS_POL : ~HS_POL;
      vs   <= vs_on ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vtc_tpg_param.sv
// Bench for vtc_tpg_param: small 24x8 raster, scoreboard plus
// directed checks of bars, ramp, checker, solid, en drop, reset, wrap.
module tb_vtc_tpg_param;

  localparam int HT = 24;
  localparam int VT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] solid_color;
  logic        vs, hs, de, sof;
  logic [23:0] data;
  logic [15:0] frame_cnt;

  vtc_tpg_param #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .DATA_W(8), .CH(3), .CELL_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .solid_color(solid_color),
    .vs(vs), .hs(hs), .de(de), .data(data),
    .sof(sof), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] BAR [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  int nvec = 0;
  int nerr = 0;

  int          m_h, m_v;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;
  logic [15:0] m_fc;
  logic [43:0] exp_q [$];

  task automatic chk(input string tag, input logic [43:0] obs,
                     input logic [43:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] ref_pix(int h, int v,
      logic [1:0] md, logic [23:0] sc);
    case (md)
      2'd0: ref_pix = BAR[(h / 2 > 7) ? 7 : h / 2];
      2'd1: ref_pix = (((h >> 2) ^ (v >> 2)) & 1) != 0 ?
                      24'hFFFFFF : 24'h000000;
      2'd2: ref_pix = {3{8'(h)}};
      default: ref_pix = sc;
    endcase
  endfunction

  // Expected {de,hs,vs,sof,data,frame_cnt} after the coming edge.
  function automatic logic [43:0] ref_out();
    logic        e_de, e_hs, e_vs, e_sof;
    logic [23:0] e_d;
    logic [15:0] e_fc;
    logic [1:0]  md;
    logic [23:0] sc;
    e_de = 0; e_hs = 0; e_vs = 0; e_sof = 0; e_d = '0;
    e_fc = m_fc;
    if (rst) begin
      e_fc = '0;
    end else if (en) begin
      md    = (m_h == 0 && m_v == 0) ? mode : m_mode;
      sc    = (m_h == 0 && m_v == 0) ? solid_color : m_solid;
      e_de  = (m_h < 16) && (m_v < 4);
      e_hs  = (m_h >= 18) && (m_h <= 20);
      e_vs  = (m_v >= 5) && (m_v <= 6);
      e_sof = (m_h == 0) && (m_v == 0);
      e_d   = e_de ? ref_pix(m_h, m_v, md, sc) : 24'h0;
      if (m_h == HT - 1 && m_v == VT - 1) e_fc = m_fc + 16'd1;
    end
    return {e_de, e_hs, e_vs, e_sof, e_d, e_fc};
  endfunction

  task automatic model_adv();
    if (rst) begin
      m_h = 0; m_v = 0; m_mode = '0; m_solid = '0; m_fc = '0;
    end else if (!en) begin
      m_h = 0; m_v = 0;
    end else begin
      if (m_h == 0 && m_v == 0) begin
        m_mode = mode; m_solid = solid_color;
      end
      if (m_h == HT - 1 && m_v == VT - 1) m_fc = m_fc + 16'd1;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
  endtask

  task automatic step();
    exp_q.push_back(ref_out());
    @(posedge clk);
    #1;
    model_adv();
    chk("sb", {de, hs, vs, sof, data, frame_cnt}, exp_q.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 400 && !(m_h == h && m_v == v); i++) step();
  endtask

  initial begin
    logic [15:0] fc_hold;
    m_h = 0; m_v = 0; m_mode = '0; m_solid = '0; m_fc = '0;
    rst = 1; en = 0; mode = 2'd0; solid_color = 24'h0;
    #2;
    run(3);
    chk("rst_state", {de, hs, vs, sof, data, frame_cnt}, 44'h0);

    // first frame: bars, line timing
    rst = 0; en = 1;
    for (int i = 0; i < HT; i++) begin
      step();
      chk("de_line", {43'h0, de}, {43'h0, i < 16});
      chk("hs_line", {43'h0, hs}, {43'h0, (i >= 18 && i <= 20)});
      if (i == 0) chk("sof_first", {43'h0, sof}, 44'h1);
      if (i < 16) chk("bar_pix", {20'h0, data}, {20'h0, BAR[i / 2]});
    end
    run_to(0, 5);
    step();
    chk("vs_line5", {43'h0, vs}, 44'h1);

    // switch to ramp mid-frame; next frame line 0 is a ramp
    mode = 2'd2;
    run_to(0, 0);
    chk("fc_one", {28'h0, frame_cnt}, 44'h1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("ramp_pix", {20'h0, data}, {20'h0, {3{8'(i)}}});
    end

    // checker
    mode = 2'd1;
    run_to(0, 0);
    run(8);
    chk("chk_l0p7", {20'h0, data}, {20'h0, 24'hFFFFFF});
    run_to(0, 4);
    mode = 2'd3; solid_color = 24'h123456;
    run_to(0, 0);
    step();
    chk("solid_p0", {20'h0, data}, {20'h0, 24'h123456});
    run(HT * VT - 1);

    // en drop at line 2 pixel 5
    run_to(5, 2);
    fc_hold = frame_cnt;
    en = 0;
    step();
    chk("endrop_de", {43'h0, de}, 44'h0);
    chk("endrop_fc", {28'h0, frame_cnt}, {28'h0, fc_hold});
    run(5);
    en = 1;
    step();
    chk("reen_sof", {42'h0, sof, de}, 44'h3);
    run(40);

    // reset mid-frame
    rst = 1;
    step();
    chk("midrst", {de, hs, vs, sof, data, frame_cnt}, 44'h0);
    rst = 0; en = 0;
    run(2);

    // frame counter wrap
    force dut.frame_cnt = 16'hFFFF;
    #2;
    release dut.frame_cnt;
    m_fc = 16'hFFFF;
    run(1);
    en = 1;
    run(HT * VT);
    chk("fc_wrap", {28'h0, frame_cnt}, 44'h0);
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
